// File: rtl/hazard_issue_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// hazard_issue_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared pipeline definitions for the decode-stage issue/stall controller:
//   - issue FSM state encoding
//   - bit layout of the 14-bit forwarding packet and the bubble packet
//   - operand forward-select encodings
//   - helper that packs a forwarding packet
// Revision: 1.0 - initial release
// ============================================================================
package hazard_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STALL  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  // Forwarding packet layout: {memtoreg, regwrite, dst, src1, src0}
  localparam int FWD_W        = 14;
  localparam int MEMTOREG_BIT = 13;
  localparam int REGWRITE_BIT = 12;
  localparam int DST_MSB      = 11;
  localparam int DST_LSB      = 8;
  localparam int SRC1_MSB     = 7;
  localparam int SRC1_LSB     = 4;
  localparam int SRC0_MSB     = 3;
  localparam int SRC0_LSB     = 0;

  // regwrite=0 in the bubble, so forwarding history never matches it
  localparam logic [FWD_W-1:0] FWD_BUBBLE = 14'h0000;

  // Operand forward-select encodings
  localparam logic [1:0] FWD_SEL_NONE = 2'b00;
  localparam logic [1:0] FWD_SEL_EX   = 2'b01;
  localparam logic [1:0] FWD_SEL_MEM  = 2'b10;

  function automatic logic [FWD_W-1:0] pack_fwd(
    input logic       memtoreg,
    input logic       regwrite,
    input logic [3:0] dst,
    input logic [3:0] src1,
    input logic [3:0] src0
  );
    logic [FWD_W-1:0] pkt;
    pkt                     = '0;
    pkt[MEMTOREG_BIT]       = memtoreg;
    pkt[REGWRITE_BIT]       = regwrite;
    pkt[DST_MSB:DST_LSB]    = dst;
    pkt[SRC1_MSB:SRC1_LSB]  = src1;
    pkt[SRC0_MSB:SRC0_LSB]  = src0;
    return pkt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_issue_ctrl_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sat_counter
// ----------------------------------------------------------------------------
// Saturating up-counter: increments on en, sticks at all-ones.
// Ports:
//   clk   in  1      clock
//   rst   in  1      asynchronous active-high reset (clears count)
//   en    in  1      increment enable
//   count out CNT_W  current count
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// hazard_issue_ctrl
// ----------------------------------------------------------------------------
// Decode-stage issue/stall controller. Registers each decoded instruction's
// register-usage packet toward the forwarding unit, turns dataDep / taken
// branch / halt into PC, IF-ID and ID-EX control, and registers the returned
// operand selects for EX.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   dec_*                       decoded instruction fields from ID
//   ex_branch_taken             EX resolved a taken branch
//   dataDep, r0_fwd, r1_fwd     replies from the forwarding unit
//   FWD_out                     registered packet to the forwarding unit
//   pc_we, ifid_we, ifid_flush, idex_bubble   combinational pipe control
//   ex_sel0, ex_sel1            registered operand selects for EX
//   halted                      core halted (registered)
//   stall_cnt                   saturating count of load-use stall cycles
// Revision: 1.0 - initial release
// ============================================================================
module hazard_issue_ctrl
  import hazard_issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [3:0]       dec_src0,
  input  logic [3:0]       dec_src1,
  input  logic [3:0]       dec_dst,
  input  logic             dec_regwrite,
  input  logic             dec_memtoreg,
  input  logic             dec_halt,
  input  logic             ex_branch_taken,
  input  logic             dataDep,
  input  logic [1:0]       r0_fwd,
  input  logic [1:0]       r1_fwd,
  output logic [13:0]      FWD_out,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       ex_sel0,
  output logic [1:0]       ex_sel1,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state, next_state;
  logic [2:0] phase_cnt, next_phase_cnt;
  logic       issue_bubble;
  logic       halt_req;

  assign halt_req = dec_valid && dec_halt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      phase_cnt <= 3'd0;
    end else begin
      state     <= next_state;
      phase_cnt <= next_phase_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and pipe control. Priority: branch > dataDep > halt.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state     = state;
    next_phase_cnt = phase_cnt;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    issue_bubble   = 1'b1;

    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          next_state     = FLUSH;
          next_phase_cnt = FLUSH_LOAD;
        end else if (dataDep) begin
          // The packet just issued needs a load result: replace this
          // issue with a bubble so the stall cycle shows an empty packet.
          next_state = STALL;
        end else begin
          issue_bubble = !dec_valid;
          if (halt_req) begin
            next_state     = DRAIN;
            next_phase_cnt = DRAIN_LOAD;
          end
        end
      end

      STALL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        if (ex_branch_taken) begin
          next_state     = FLUSH;
          next_phase_cnt = FLUSH_LOAD;
        end else begin
          // Re-issue the instruction held in IF/ID; a halt is looked at
          // again here, on the re-issue.
          issue_bubble = !dec_valid;
          if (halt_req) begin
            next_state     = DRAIN;
            next_phase_cnt = DRAIN_LOAD;
          end else begin
            next_state = RUN;
          end
        end
      end

      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (ex_branch_taken) begin
          next_phase_cnt = FLUSH_LOAD;
        end else if (phase_cnt == 3'd0) begin
          next_state = RUN;
        end else begin
          next_phase_cnt = phase_cnt - 3'd1;
        end
      end

      DRAIN: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        if (ex_branch_taken) begin
          next_state     = FLUSH;
          next_phase_cnt = FLUSH_LOAD;
        end else if (phase_cnt == 3'd0) begin
          next_state = HALTED;
        end else begin
          next_phase_cnt = phase_cnt - 3'd1;
        end
      end

      HALTED: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end

      default: begin
        next_state = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered packet, operand selects and halt flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FWD_out <= FWD_BUBBLE;
      ex_sel0 <= FWD_SEL_NONE;
      ex_sel1 <= FWD_SEL_NONE;
      halted  <= 1'b0;
    end else begin
      FWD_out <= issue_bubble ? FWD_BUBBLE
                              : pack_fwd(dec_memtoreg, dec_regwrite, dec_dst,
                                         dec_src1, dec_src0);
      ex_sel0 <= issue_bubble ? FWD_SEL_NONE : r0_fwd;
      ex_sel1 <= issue_bubble ? FWD_SEL_NONE : r1_fwd;
      halted  <= (next_state == HALTED);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state == STALL),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_hazard_issue_ctrl
// ----------------------------------------------------------------------------
// Directed-vector bench for hazard_issue_ctrl. A narrow stall counter is
// used so that saturation is reachable in a short run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_issue_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             dec_valid, dec_regwrite, dec_memtoreg, dec_halt;
  logic [3:0]       dec_src0, dec_src1, dec_dst;
  logic             ex_branch_taken, dataDep;
  logic [1:0]       r0_fwd, r1_fwd;
  logic [13:0]      FWD_out;
  logic             pc_we, ifid_we, ifid_flush, idex_bubble, halted;
  logic [1:0]       ex_sel0, ex_sel1;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  hazard_issue_ctrl #(
    .FLUSH_CYCLES (2),
    .DRAIN_CYCLES (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_valid       (dec_valid),
    .dec_src0        (dec_src0),
    .dec_src1        (dec_src1),
    .dec_dst         (dec_dst),
    .dec_regwrite    (dec_regwrite),
    .dec_memtoreg    (dec_memtoreg),
    .dec_halt        (dec_halt),
    .ex_branch_taken (ex_branch_taken),
    .dataDep         (dataDep),
    .r0_fwd          (r0_fwd),
    .r1_fwd          (r1_fwd),
    .FWD_out         (FWD_out),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .ex_sel0         (ex_sel0),
    .ex_sel1         (ex_sel1),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic mtr, input logic rw,
                         input logic [3:0] dst, input logic [3:0] s1,
                         input logic [3:0] s0, input logic h);
    dec_valid    = v;
    dec_memtoreg = mtr;
    dec_regwrite = rw;
    dec_dst      = dst;
    dec_src1     = s1;
    dec_src0     = s0;
    dec_halt     = h;
  endtask

  task automatic check_ctrl(input string tag, input logic pcw, input logic ifw,
                            input logic fl, input logic bub);
    check_eq({tag, ".pc_we"},       16'(pc_we),       16'(pcw));
    check_eq({tag, ".ifid_we"},     16'(ifid_we),     16'(ifw));
    check_eq({tag, ".ifid_flush"},  16'(ifid_flush),  16'(fl));
    check_eq({tag, ".idex_bubble"}, 16'(idex_bubble), 16'(bub));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_dec(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    ex_branch_taken = 1'b0;
    dataDep         = 1'b0;
    r0_fwd          = 2'b00;
    r1_fwd          = 2'b00;

    // ---------------- reset values ----------------
    #12;
    check_eq("rst.FWD_out",   16'(FWD_out),   16'h0000);
    check_eq("rst.ex_sel0",   16'(ex_sel0),   16'h0);
    check_eq("rst.ex_sel1",   16'(ex_sel1),   16'h0);
    check_eq("rst.stall_cnt", 16'(stall_cnt), 16'h0);
    check_eq("rst.halted",    16'(halted),    16'h0);
    check_ctrl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // ---------------- ADD r3 then SUB r5,r3,r1 ----------------
    set_dec(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 4'd1, 1'b0);
    step();
    check_eq("add.FWD_out", 16'(FWD_out), 16'h1331);
    set_dec(1'b1, 1'b0, 1'b1, 4'd5, 4'd1, 4'd3, 1'b0);
    r0_fwd = 2'b01;
    r1_fwd = 2'b10;
    step();
    check_eq("sub.FWD_out", 16'(FWD_out), 16'h1513);
    check_eq("sub.ex_sel0", 16'(ex_sel0), 16'h1);
    check_eq("sub.ex_sel1", 16'(ex_sel1), 16'h2);
    check_ctrl("sub", 1'b1, 1'b1, 1'b0, 1'b0);
    set_dec(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    // dec_valid=0 issued a bubble: selects forced to NONE
    check_eq("idle.FWD_out", 16'(FWD_out), 16'h0000);
    check_eq("idle.ex_sel0", 16'(ex_sel0), 16'h0);
    check_eq("idle.stall_cnt", 16'(stall_cnt), 16'h0);
    r0_fwd = 2'b00;
    r1_fwd = 2'b00;

    // ---------------- LW r2 then ADD r4,r2,r2 with load-use ----------------
    set_dec(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 4'd1, 1'b0);
    step();
    check_eq("lw.FWD_out", 16'(FWD_out), 16'h3201);
    set_dec(1'b1, 1'b0, 1'b1, 4'd4, 4'd2, 4'd2, 1'b0);
    step();
    check_eq("lu_add.FWD_out", 16'(FWD_out), 16'h1422);
    dataDep = 1'b1;
    r0_fwd  = 2'b10;
    step();
    check_ctrl("stall", 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("stall.FWD_out", 16'(FWD_out), 16'h0000);
    check_eq("stall.ex_sel0", 16'(ex_sel0), 16'h0);
    dataDep = 1'b0;
    r0_fwd  = 2'b00;
    step();
    check_eq("reissue.FWD_out", 16'(FWD_out), 16'h1422);
    check_eq("reissue.stall_cnt", 16'(stall_cnt), 16'h1);
    check_ctrl("reissue", 1'b1, 1'b1, 1'b0, 1'b0);

    // ---------------- taken branch, dataDep ignored in FLUSH ----------------
    ex_branch_taken = 1'b1;
    step();
    check_ctrl("flush1", 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("flush1.FWD_out", 16'(FWD_out), 16'h0000);
    ex_branch_taken = 1'b0;
    dataDep         = 1'b1;
    step();
    check_ctrl("flush2", 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("flush2.FWD_out", 16'(FWD_out), 16'h0000);
    dataDep = 1'b0;
    step();
    check_ctrl("post_flush", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("post_flush.stall_cnt", 16'(stall_cnt), 16'h1);
    step();
    check_eq("post_flush.FWD_out", 16'(FWD_out), 16'h1422);

    // ---------------- HALT with a 3-cycle drain ----------------
    set_dec(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, 1'b1);
    step();
    check_eq("halt.FWD_out", 16'(FWD_out), 16'h0007);
    for (int i = 0; i < 3; i++) begin
      set_dec(i[0], 1'b0, 1'b1, 4'd6, 4'd1, 4'd1, 1'b0);
      check_ctrl($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq($sformatf("drain%0d.halted", i), 16'(halted), 16'h0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_dec(~i[0], 1'b0, 1'b1, 4'd6, 4'd1, 4'd1, 1'b0);
      check_eq($sformatf("halted%0d", i), 16'(halted), 16'h1);
      check_ctrl($sformatf("halted%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq($sformatf("halted%0d.FWD_out", i), 16'(FWD_out), 16'h0000);
      step();
    end

    // ---------------- reset out of HALTED, then reset mid-FLUSH -----------
    set_dec(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rst_halt.halted", 16'(halted), 16'h0);
    step();
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    check_eq("pre_rst.ifid_flush", 16'(ifid_flush), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check_ctrl("rst_flush", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_flush.FWD_out",   16'(FWD_out),   16'h0000);
    check_eq("rst_flush.stall_cnt", 16'(stall_cnt), 16'h0);
    step();
    rst = 1'b0;
    step();
    set_dec(1'b1, 1'b0, 1'b1, 4'd5, 4'd1, 4'd3, 1'b0);
    check_eq("rst_rel.FWD_out", 16'(FWD_out), 16'h0000);
    step();
    check_eq("rst_rel.first_pkt", 16'(FWD_out), 16'h1513);

    // ---------------- stall counter saturation (2^CNT_W + 3 stalls) -------
    exp_cnt = 0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      dataDep = 1'b1;
      step();
      dataDep = 1'b0;
      step();
      exp_cnt = (exp_cnt == (1 << CNT_W) - 1) ? exp_cnt : exp_cnt + 1;
      check_eq($sformatf("sat%0d.stall_cnt", i), 16'(stall_cnt), 16'(exp_cnt));
    end
    check_eq("sat.final", 16'(stall_cnt), 16'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
